// File: rtl/dst_pkg.sv
// Shared defaults and FSM state encoding for the denormalize_stream slice.
package dst_pkg;
  localparam int DST_IN_W  = 16;
  localparam int DST_OUT_W = 24;
  localparam int DST_SHIFT = 14;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } dst_state_e;
endpackage

// File: rtl/denorm_elem.sv
// One coefficient scaled by 2^SHIFT and reduced to OUT_W bits.
// DENORM_SAT_EN selects saturation with a clip flag; otherwise the result wraps.
module denorm_elem
  import dst_pkg::*;
#(
  parameter int IN_W  = DST_IN_W,
  parameter int OUT_W = DST_OUT_W,
  parameter int SHIFT = DST_SHIFT
) (
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_clip
);
  localparam int WW = IN_W + SHIFT;

  logic signed [WW-1:0] w_wide;
  assign w_wide = {i_x, {SHIFT{1'b0}}};

  generate
    if (WW > OUT_W) begin : g_reduce
`ifdef DENORM_SAT_EN
      // Value fits only when every bit above the OUT_W sign bit copies it.
      logic [WW-OUT_W:0] w_top;
      logic              w_ovf;
      assign w_top  = w_wide[WW-1:OUT_W-1];
      assign w_ovf  = ~((&w_top) | ~(|w_top));
      assign o_clip = w_ovf;
      always_comb begin
        if (w_ovf) begin
          o_y = w_wide[WW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          o_y = w_wide[OUT_W-1:0];
        end
      end
`else
      assign o_y    = w_wide[OUT_W-1:0];
      assign o_clip = 1'b0;
`endif
    end else begin : g_extend
      assign o_y    = OUT_W'(w_wide);
      assign o_clip = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/denormalize_stream.sv
// Collects four rows into a scaled 4x4 block and presents it with a valid/ready handshake.
// Optional saturation is enabled by defining DENORM_SAT_EN.
module denormalize_stream
  import dst_pkg::*;
#(
  parameter int IN_W  = DST_IN_W,
  parameter int OUT_W = DST_OUT_W,
  parameter int SHIFT = DST_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_row    [0:3],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_block [0:3][0:3],
  output logic                    out_sat
);
  dst_state_e              r_state;
  logic [1:0]              r_cnt;
  logic                    r_sat;
  logic signed [OUT_W-1:0] r_block [0:3][0:3];

  logic signed [OUT_W-1:0] w_elem [0:3];
  logic [3:0]              w_clip;
  logic                    w_accept;
  logic                    w_release;

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      denorm_elem #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT)
      ) u_elem (
        .i_x   (in_row[c]),
        .o_y   (w_elem[c]),
        .o_clip(w_clip[c])
      );
    end
  endgenerate

  assign w_accept  = in_valid && (r_state == ST_FILL);
  assign w_release = out_ready && (r_state == ST_HOLD);

  // The row counter wraps 3 -> 0 on the fourth row, so it already reads 0 in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_cnt   <= 2'd0;
      r_sat   <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_block[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int c = 0; c < 4; c++) begin
        r_block[r_cnt][c] <= w_elem[c];
      end
      r_cnt <= r_cnt + 2'd1;
      r_sat <= r_sat | (|w_clip);
      if (r_cnt == 2'd3) begin
        r_state <= ST_HOLD;
      end
    end else if (w_release) begin
      r_state <= ST_FILL;
      r_sat   <= 1'b0;
    end
  end

  assign in_ready  = (r_state == ST_FILL);
  assign out_valid = (r_state == ST_HOLD);
  assign out_sat   = r_sat;
  assign out_block = r_block;
endmodule

// File: tb/tb_denormalize_stream.sv
// Directed self-checking bench for denormalize_stream (honours DENORM_SAT_EN).
module tb_denormalize_stream;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [15:0] in_row    [0:3];
  logic signed [23:0] out_block [0:3][0:3];

  int checks = 0;
  int errors = 0;
  int rows    [0:3][0:3];
  int exp_blk [0:3][0:3];

  always #5 clk = ~clk;

  denormalize_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block),
    .out_sat  (out_sat)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input int base, input int step);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rows[r][c]    = base + step * (r * 4 + c);
        exp_blk[r][c] = rows[r][c] * 16384;
      end
    end
  endtask

  // Present row r until accepted (bounded), then drop in_valid.
  task automatic push(input int r);
    int   n;
    logic acc;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) in_row[c] = rows[r][c][15:0];
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check($sformatf("push_accept_row%0d", r), {63'd0, acc}, 64'sd1);
  endtask

  task automatic check_block(input string tag);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s[%0d][%0d]", tag, r, c), out_block[r][c], exp_blk[r][c]);
      end
    end
  endtask

  task automatic finish_block(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'sd0);
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'sd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) in_row[c] = 16'sd0;
    tick();
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'sd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'sd0);
    check("rst_out_sat", {63'd0, out_sat}, 64'sd0);
    for (int r = 0; r < 4; r++) exp_blk[r] = '{0, 0, 0, 0};
    check_block("rst_block");
    rst = 1'b0;
    tick();

    // All ones, back to back: out_valid appears right after the fourth accept.
    set_rows(1, 0);
    push(0); push(1); push(2);
    check("ones_valid_early", {63'd0, out_valid}, 64'sd0);
    push(3);
    check("ones_valid", {63'd0, out_valid}, 64'sd1);
    check("ones_in_ready", {63'd0, in_ready}, 64'sd0);
    check("ones_sat", {63'd0, out_sat}, 64'sd0);
    check_block("ones");
    finish_block("ones");

    set_rows(-1, 0);
    push(0); push(1); push(2); push(3);
    check("neg_valid", {63'd0, out_valid}, 64'sd1);
    check("neg_sat", {63'd0, out_sat}, 64'sd0);
    check_block("neg");
    finish_block("neg");

    // Range-reduction boundaries in row 0.
    set_rows(0, 0);
    rows[0] = '{511, 512, -512, -513};
`ifdef DENORM_SAT_EN
    exp_blk[0] = '{8372224, 8388607, -8388608, -8388608};
`else
    exp_blk[0] = '{8372224, -8388608, -8388608, 8372224};
`endif
    push(0); push(1); push(2); push(3);
`ifdef DENORM_SAT_EN
    check("bound_sat", {63'd0, out_sat}, 64'sd1);
`else
    check("bound_sat", {63'd0, out_sat}, 64'sd0);
`endif
    check_block("bound");
    finish_block("bound");

    // Stall in HOLD with a pending row; sat flag must have been cleared.
    set_rows(-8, 1);
    push(0); push(1); push(2); push(3);
    check("stall_sat", {63'd0, out_sat}, 64'sd0);
    check_block("stall");
    in_valid = 1'b1;
    in_row   = '{16'sd100, 16'sd101, 16'sd102, 16'sd103};
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_in_ready%0d", i), {63'd0, in_ready}, 64'sd0);
      check($sformatf("stall_valid%0d", i), {63'd0, out_valid}, 64'sd1);
      check($sformatf("stall_b00_%0d", i), out_block[0][0], -64'sd131072);
      check($sformatf("stall_b33_%0d", i), out_block[3][3], 64'sd114688);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release_valid", {63'd0, out_valid}, 64'sd0);
    set_rows(100, 1);
    push(0); push(1); push(2); push(3);
    check("after_stall_valid", {63'd0, out_valid}, 64'sd1);
    check_block("after_stall");
    finish_block("after_stall");

    // Reset after two rows discards the partial block.
    set_rows(20, -3);
    push(0); push(1);
    rst = 1'b1;
    tick();
    check("midrst_valid", {63'd0, out_valid}, 64'sd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'sd1);
    check("midrst_b00", out_block[0][0], 64'sd0);
    check("midrst_b13", out_block[1][3], 64'sd0);
    rst = 1'b0;
    tick();
    push(0); push(1); push(2);
    check("midrst_valid_early", {63'd0, out_valid}, 64'sd0);
    push(3);
    check("fresh_valid", {63'd0, out_valid}, 64'sd1);
    check_block("fresh");
    finish_block("fresh");

    // in_valid toggles every other cycle.
    set_rows(-30, 2);
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) in_row[c] = rows[r][c][15:0];
      tick();
      in_valid = 1'b0;
      check($sformatf("gap_valid_row%0d", r), {63'd0, out_valid}, (r == 3) ? 64'sd1 : 64'sd0);
      tick();
    end
    check("gap_valid_hold", {63'd0, out_valid}, 64'sd1);
    check_block("gap");
    finish_block("gap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/denormalize_stream.md
DENORMALIZE_STREAM -- requirements
Module: denormalize_stream

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning signed input coefficient width.
REQ-002 SHALL have parameter OUT_W, default 24, meaning signed output sample width.
REQ-003 SHALL have parameter SHIFT, default 14, meaning left-shift amount (scale 2^SHIFT).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, meaning in_row holds a valid row.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a row this cycle.
REQ-008 SHALL have port in_row, input, signed [IN_W-1:0] x [0:3], meaning one row of a 4x4 coefficient block.
REQ-009 SHALL have port out_valid, output, 1, meaning out_block holds a complete scaled block.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts out_block.
REQ-011 SHALL have port out_block, output, signed [OUT_W-1:0] x [0:3][0:3], meaning the scaled 4x4 block.
REQ-012 SHALL have port out_sat, output, 1, meaning at least one element of out_block was clipped.

Function
REQ-013 SHALL accept a row on any cycle with in_valid and in_ready both high.
REQ-014 SHALL run FSM states FILL and HOLD; FILL -> HOLD when the fourth row is accepted; HOLD -> FILL when out_valid and out_ready are both high.
REQ-015 SHALL drive in_ready high in FILL and low in HOLD; out_valid high exactly in HOLD.
REQ-016 SHALL keep a 2-bit row counter: 0 in HOLD, incremented per accepted row in FILL, wrapping 3 -> 0 on the FILL -> HOLD transition.
REQ-017 SHALL write the accepted row to out_block[row counter][0:3] in the acceptance cycle.
REQ-018 SHALL compute each element as the sign-extended input times 2^SHIFT in IN_W+SHIFT bits, with no rounding and no precision loss before range reduction.
REQ-019 SHALL assert out_valid the cycle after the fourth row is accepted, giving a minimum block period of 5 cycles.
REQ-020 SHALL hold out_block, out_sat and out_valid stable in HOLD until the handshake completes, regardless of in_valid.
REQ-021 SHALL clear the block's clip accumulator on HOLD -> FILL and OR in each element's clip indication as rows are accepted.
REQ-022 SHALL leave state unchanged in FILL while in_valid is low (rows may arrive with gaps).

Reset
REQ-023 SHALL, while rst is high, force state FILL, row counter 0, out_valid 0, out_sat 0, out_block all zeros, and in_ready 1.
REQ-024 SHALL discard a partially filled or unacknowledged block on reset mid-operation; no output handshake completes for it.

Configuration
REQ-025 SHALL, with DENORM_SAT_EN defined, saturate each element to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and flag clips through out_sat.
REQ-026 SHALL, without DENORM_SAT_EN, truncate each element to its OUT_W low bits (two's-complement wrap) and tie out_sat to 0.

Structure
REQ-027 SHALL take default widths, SHIFT and the FSM state enum from shared package dst_pkg.
REQ-028 SHALL place the per-element scale/saturate logic in combinational sub-module denorm_elem, instantiated once per row column (4 instances).

Verification
REQ-029 SHALL cover: rows all 1, then all -1 -> out_block elements 16384 and -16384, out_sat 0, out_valid on the 5th cycle.
REQ-030 SHALL cover, with the macro: elements 511, 512, -512, -513 -> 8372224, 8388607, -8388608, -8388608, out_sat 1.
REQ-031 SHALL cover, without the macro: element 512 -> -8388608 (wrap), out_sat 0.
REQ-032 SHALL cover out_ready low for 3 cycles in HOLD with in_valid high -> in_ready 0, out_block stable, no row lost; next block correct after release.
REQ-033 SHALL cover rst asserted after 2 rows accepted -> out_valid 0; the next 4 rows form a complete fresh block.
REQ-034 SHALL cover in_valid toggling every other cycle -> block completes after 4 accepted rows, rows in order 0..3.
